// File: rtl/env_alert_uart.sv
// Threshold-driven ventilator control with an 18-byte ASCII alert frame sent over 8N1 UART on every change.
// Optional periodic reporting is enabled by defining ENV_ALERT_PERIODIC_EN.
module env_alert_uart #(
`ifdef ENV_ALERT_PERIODIC_EN
  parameter int unsigned REPORT_CYCLES = 250000000,
`endif
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned EVAL_CYCLES = 5000000,
  parameter logic [15:0] T_ON        = 16'h6000,
  parameter logic [15:0] T_OFF       = 16'h5800,
  parameter logic [15:0] H_ON        = 16'hC000,
  parameter logic [15:0] H_OFF       = 16'hB800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] temp_in,
  input  logic [15:0] hum_in,
  output logic        vent,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned BIT_CLKS = CLK_HZ / BAUD;
  localparam int unsigned BIT_W    = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam int unsigned EVAL_W   = (EVAL_CYCLES > 2) ? $clog2(EVAL_CYCLES) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BIT_CLKS - 1);
  // The NEXT state supplies the final clock of the stop bit.
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(BIT_CLKS - 2);
  localparam logic [EVAL_W-1:0] EVAL_LAST = EVAL_W'(EVAL_CYCLES - 1);
  localparam logic [4:0]        LAST_BYTE = 5'd17;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, NEXT} state_e;

  logic [15:0]       temp_s1_q, temp_s2_q, hum_s1_q, hum_s2_q;
  logic [EVAL_W-1:0] eval_cnt_q;
  logic              eval_tick;
  logic              vent_q, vent_d, vent_change;
  logic              pending_q, pending_d;
  logic              report_tick;

  state_e            state_q;
  logic              tx_q, busy_q;
  logic [7:0]        frame_cnt_q;
  logic [4:0]        byte_idx_q;
  logic [2:0]        bit_idx_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              snap_vent_q;
  logic [15:0]       snap_temp_q, snap_hum_q;
  logic [7:0]        cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign eval_tick = (eval_cnt_q == EVAL_LAST);

  always_comb begin
    // NOTE: default first so every path assigns vent_d and no latch is inferred.
    vent_d = vent_q;
    if (eval_tick) begin
      if (!vent_q && (temp_s2_q >= T_ON || hum_s2_q >= H_ON)) begin
        vent_d = 1'b1;
      end else if (vent_q && temp_s2_q < T_OFF && hum_s2_q < H_OFF) begin
        vent_d = 1'b0;
      end
    end
  end

  assign vent_change = (vent_d != vent_q);

  // A new request arriving on the LOAD cycle must not be lost, so set wins.
  always_comb begin
    pending_d = pending_q;
    if (state_q == LOAD) pending_d = 1'b0;
    if (vent_change || report_tick) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      temp_s1_q  <= '0;
      temp_s2_q  <= '0;
      hum_s1_q   <= '0;
      hum_s2_q   <= '0;
      eval_cnt_q <= '0;
      vent_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so the second sync stage takes the first stage's old value.
      temp_s1_q  <= temp_in;
      temp_s2_q  <= temp_s1_q;
      hum_s1_q   <= hum_in;
      hum_s2_q   <= hum_s1_q;
      eval_cnt_q <= eval_tick ? '0 : eval_cnt_q + EVAL_W'(1);
      vent_q     <= vent_d;
      pending_q  <= pending_d;
    end
  end

`ifdef ENV_ALERT_PERIODIC_EN
  localparam int unsigned RPT_W = (REPORT_CYCLES > 2) ? $clog2(REPORT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPORT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_cnt_q;

  assign report_tick = (rpt_cnt_q == RPT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt_q <= '0;
    end else if (report_tick || vent_change) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
    end
  end
`else
  assign report_tick = 1'b0;
`endif

  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx_q)
      5'd0:    cur_byte = "V";
      5'd1:    cur_byte = snap_vent_q ? "1" : "0";
      5'd2:    cur_byte = " ";
      5'd3:    cur_byte = "T";
      5'd4:    cur_byte = "=";
      5'd5:    cur_byte = hex_char(snap_temp_q[15:12]);
      5'd6:    cur_byte = hex_char(snap_temp_q[11:8]);
      5'd7:    cur_byte = hex_char(snap_temp_q[7:4]);
      5'd8:    cur_byte = hex_char(snap_temp_q[3:0]);
      5'd9:    cur_byte = " ";
      5'd10:   cur_byte = "H";
      5'd11:   cur_byte = "=";
      5'd12:   cur_byte = hex_char(snap_hum_q[15:12]);
      5'd13:   cur_byte = hex_char(snap_hum_q[11:8]);
      5'd14:   cur_byte = hex_char(snap_hum_q[7:4]);
      5'd15:   cur_byte = hex_char(snap_hum_q[3:0]);
      5'd16:   cur_byte = 8'h0D;
      5'd17:   cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
      bit_cnt_q   <= '0;
      snap_vent_q <= 1'b0;
      snap_temp_q <= '0;
      snap_hum_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (pending_q) state_q <= LOAD;
        LOAD: begin
          snap_vent_q <= vent_q;
          snap_temp_q <= temp_s2_q;
          snap_hum_q  <= hum_s2_q;
          busy_q      <= 1'b1;
          byte_idx_q  <= '0;
          bit_cnt_q   <= '0;
          tx_q        <= 1'b0;
          state_q     <= START;
        end
        START: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= DATA;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        STOP: begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_q <= '0;
            state_q   <= NEXT;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        NEXT: begin
          if (byte_idx_q == LAST_BYTE) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            byte_idx_q <= byte_idx_q + 5'd1;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vent      = vent_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule
